// File: rtl/shift_pkg.sv
// Shared op codes and the per-stage record for shift_rotate_pipe.
// SHIFT_FLAGS_EN adds the carry/zero fields carried down the pipeline.
package shift_pkg;

  localparam int OP_W      = 3;
  localparam int MAX_W     = 64;
  localparam int MAX_LOGW  = 6;
  localparam int MAX_TAG_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_SRA = 3'd4
  } op_e;

  // Sized for the widest configuration; narrower builds leave the upper bits at zero.
  typedef struct packed {
    logic [MAX_W-1:0]     data;
    logic [OP_W-1:0]      op;
    logic [MAX_LOGW-1:0]  amt;
    logic [MAX_TAG_W-1:0] tag;
    logic                 valid;
    logic                 fill;
`ifdef SHIFT_FLAGS_EN
    logic                 carry;
    logic                 zero;
`endif
  } stage_rec_t;

  // Codes above SRA are pass-through and never move the operand.
  function automatic logic is_move_op(input logic [OP_W-1:0] op);
    return op <= OP_SRA;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered barrel stage: moves the operand by 2**K when residual amount bit K is set.
// With SHIFT_FLAGS_EN the stage also tracks the last bit shifted out and the zero flag.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_adv,
  input  stage_rec_t i_rec,
  output stage_rec_t o_rec
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_mv;
  logic             w_act;
  stage_rec_t       w_nxt;
  stage_rec_t       r_rec;

  always_comb begin
    w_d   = i_rec.data[WIDTH-1:0];
    w_act = i_rec.amt[K] && is_move_op(i_rec.op);
    w_mv  = w_d;
    if (w_act) begin
      case (i_rec.op)
        OP_ROL:  w_mv = {w_d[WIDTH-S-1:0], w_d[WIDTH-1:WIDTH-S]};
        OP_ROR:  w_mv = {w_d[S-1:0], w_d[WIDTH-1:S]};
        OP_SHL:  w_mv = {w_d[WIDTH-S-1:0], {S{1'b0}}};
        OP_SHR:  w_mv = {{S{1'b0}}, w_d[WIDTH-1:S]};
        OP_SRA:  w_mv = {{S{i_rec.fill}}, w_d[WIDTH-1:S]};
        default: w_mv = w_d;
      endcase
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic w_co;

  // Left moves lose bit WIDTH-S last, right moves lose bit S-1 last; rotates see the same bit land at the far end.
  always_comb begin
    w_co = i_rec.carry;
    if (w_act) begin
      case (i_rec.op)
        OP_ROL, OP_SHL: w_co = w_d[WIDTH-S];
        default:        w_co = w_d[S-1];
      endcase
    end
  end
`endif

  always_comb begin
    w_nxt                 = i_rec;
    w_nxt.data[WIDTH-1:0] = w_mv;
    w_nxt.amt[K]          = 1'b0;
`ifdef SHIFT_FLAGS_EN
    w_nxt.carry           = w_co;
    w_nxt.zero            = (w_mv == '0);
`endif
  end

  // Bubbles only clear valid, so the payload of the last real operation stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rec <= '0;
    end else if (i_adv) begin
      if (i_rec.valid) begin
        r_rec <= w_nxt;
      end else begin
        r_rec.valid <= 1'b0;
      end
    end
  end

  assign o_rec = r_rec;

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined ROL/ROR/SHL/SHR/SRA unit: one registered barrel stage per amount bit, tag passed through.
// Define SHIFT_FLAGS_EN to add the registered out_carry / out_zero flags. WIDTH <= 64, TAG_W <= 16.
module shift_rotate_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int LOGW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOGW-1:0]  in_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_FLAGS_EN
  ,
  output logic             out_carry,
  output logic             out_zero
`endif
);

  stage_rec_t w_in;
  stage_rec_t w_stg [LOGW];
  logic       w_adv;
  logic       w_unused_rec;

  // Whole pipeline freezes only while a finished result waits for its consumer.
  assign w_adv    = !(w_stg[LOGW-1].valid && !out_ready);
  assign in_ready = w_adv;

  always_comb begin
    w_in                  = '0;
    w_in.data[WIDTH-1:0]  = in_data;
    w_in.op               = in_op;
    w_in.amt[LOGW-1:0]    = in_amt;
    w_in.tag[TAG_W-1:0]   = in_tag;
    w_in.valid            = in_valid;
    w_in.fill             = in_data[WIDTH-1];
  end

  for (genvar k = 0; k < LOGW; k++) begin : g_stage
    if (k == 0) begin : g_first
      shift_stage #(
        .WIDTH (WIDTH),
        .K     (k)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .i_adv (w_adv),
        .i_rec (w_in),
        .o_rec (w_stg[k])
      );
    end else begin : g_next
      shift_stage #(
        .WIDTH (WIDTH),
        .K     (k)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .i_adv (w_adv),
        .i_rec (w_stg[k-1]),
        .o_rec (w_stg[k])
      );
    end
  end

  assign out_valid = w_stg[LOGW-1].valid;
  assign out_data  = w_stg[LOGW-1].data[WIDTH-1:0];
  assign out_tag   = w_stg[LOGW-1].tag[TAG_W-1:0];
`ifdef SHIFT_FLAGS_EN
  assign out_carry = w_stg[LOGW-1].carry;
  assign out_zero  = w_stg[LOGW-1].zero;
`endif

  // Residual amount, op and padding bits of the final record have no consumer.
  assign w_unused_rec = ^w_stg[LOGW-1];

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Bench for shift_rotate_pipe (WIDTH=32): directed cases with literal results plus
// randomized traffic checked each cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_shift_rotate_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [W-1:0]  in_data = '0;
  logic [LW-1:0] in_amt = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
`ifdef SHIFT_FLAGS_EN
  logic          out_carry;
  logic          out_zero;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] tag;
    logic          c;
    int            age;
  } exp_t;

  exp_t          q[$];
  logic [TW-1:0] ret_tags[$];
  bit            saw_stall;

  shift_rotate_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef SHIFT_FLAGS_EN
    ,
    .out_carry (out_carry),
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Result and carry straight from the operation definitions.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] d,
                                         input int a, output logic c);
    logic [W-1:0] r;
    r = d;
    c = 1'b0;
    if (a != 0) begin
      case (op)
        3'd0: begin r = (d << a) | (d >> (W - a)); c = r[0];     end
        3'd1: begin r = (d >> a) | (d << (W - a)); c = r[W-1];   end
        3'd2: begin r = d << a;                    c = d[W - a]; end
        3'd3: begin r = d >> a;                    c = d[a - 1]; end
        3'd4: begin r = $signed(d) >>> a;          c = d[a - 1]; end
        default: ;
      endcase
    end
    return r;
  endfunction

  // Model: every accepted op ages by one per advancing edge and is due at the output at age LW.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      logic mv;
      logic ct;
      exp_t e;
      mv = (q.size() > 0) && (q[0].age >= LW);
      chk("out_valid", out_valid, mv);
      chk("in_ready", in_ready, !(mv && !out_ready));
      if (mv) begin
        chk("out_data", out_data, q[0].d);
        chk("out_tag", out_tag, q[0].tag);
`ifdef SHIFT_FLAGS_EN
        chk("out_carry", out_carry, q[0].c);
        chk("out_zero", out_zero, q[0].d == '0);
`endif
      end
      if (mv && !out_ready) saw_stall = 1'b1;
      if (mv && out_ready) begin
        ret_tags.push_back(q[0].tag);
        void'(q.pop_front());
      end
      if (!(mv && !out_ready)) begin
        for (int i = 0; i < q.size(); i++) begin
          e = q[i];
          e.age++;
          q[i] = e;
        end
        if (in_valid) begin
          e.d   = model(in_op, in_data, int'(in_amt), ct);
          e.c   = ct;
          e.tag = in_tag;
          e.age = 1;
          q.push_back(e);
        end
      end
    end
  end

  task automatic run_one(input logic [2:0] op, input logic [W-1:0] d, input int a,
                         input logic [TW-1:0] tg, input logic [W-1:0] exp_d,
                         input logic exp_c, input string nm);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = a[LW-1:0]; in_tag = tg; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (n < 30) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, LW);
    chk({nm, "_data"}, out_data, exp_d);
    chk({nm, "_tag"}, out_tag, tg);
`ifdef SHIFT_FLAGS_EN
    chk({nm, "_carry"}, out_carry, exp_c);
    chk({nm, "_zero"}, out_zero, exp_d == '0);
`else
    if (exp_c === 1'bx) $display("note: unknown carry expectation for %s", nm);
`endif
    @(negedge clk);
    chk({nm, "_hold"}, {out_valid, out_data}, {1'b0, exp_d});
  endtask

  initial begin
    int acc_n;
    bit acc;
    bit saw_nr;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", out_tag, 4'h0);
`ifdef SHIFT_FLAGS_EN
    chk("rst_carry", out_carry, 1'b0);
    chk("rst_zero", out_zero, 1'b0);
`endif
    #20 rst_n = 1'b1;

    run_one(3'd0, 32'h8000_0001, 1,  4'h1, 32'h0000_0003, 1'b1, "rol1");
    run_one(3'd1, 32'h1234_5678, 0,  4'h2, 32'h1234_5678, 1'b0, "ror0");
    run_one(3'd2, 32'h0000_0001, 31, 4'h3, 32'h8000_0000, 1'b0, "shl31");
    run_one(3'd4, 32'h8000_0000, 31, 4'h4, 32'hFFFF_FFFF, 1'b0, "sra31");
    run_one(3'd3, 32'h8000_0000, 31, 4'h5, 32'h0000_0001, 1'b0, "shr31");
    run_one(3'd3, 32'h0000_0001, 1,  4'h6, 32'h0000_0000, 1'b1, "shr1");
    run_one(3'd5, 32'hDEAD_BEEF, 7,  4'h7, 32'hDEAD_BEEF, 1'b0, "pass5");
    run_one(3'd1, 32'h0000_0001, 4,  4'h8, 32'h1000_0000, 1'b0, "ror4");
    run_one(3'd4, 32'h7FFF_FFFF, 4,  4'h9, 32'h07FF_FFFF, 1'b1, "sra4");

    // Backpressure: 8 ops, consumer blocked for 10 cycles.
    @(posedge clk); #1;
    saw_stall = 1'b0; saw_nr = 1'b0; ret_tags.delete(); out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int w;
          w = 0;
          in_valid = 1'b1; in_op = 3'($urandom_range(0, 4)); in_data = $urandom;
          in_amt = 5'($urandom); in_tag = i[TW-1:0];
          @(negedge clk);
          while (!in_ready && w < 100) begin
            saw_nr = 1'b1;
            @(negedge clk);
            w++;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("bp_no_retire_while_blocked", ret_tags.size(), 0);
        out_ready = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_fell", saw_nr, 1'b1);
    chk("bp_stall_seen", saw_stall, 1'b1);
    chk("bp_retired_count", ret_tags.size(), 8);
    for (int i = 0; i < 8 && i < ret_tags.size(); i++) chk("bp_tag_order", ret_tags[i], i);

    // Reset with a full, stalled pipeline.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 3'($urandom_range(0, 4)); in_data = $urandom;
      in_amt = 5'($urandom); in_tag = 4'(8 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("rmf_full_before_reset", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmf_out_valid", out_valid, 1'b0);
    chk("rmf_in_ready", in_ready, 1'b1);
    chk("rmf_out_data", out_data, 32'h0);
    chk("rmf_out_tag", out_tag, 4'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (8) @(negedge clk);
    run_one(3'd2, 32'h0000_000F, 4, 4'hA, 32'h0000_00F0, 1'b0, "post_rst");

    // Randomized traffic with random consumer backpressure.
    acc_n = 0; acc = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40000 && acc_n < 3000; cyc++) begin
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          int sel;
          sel = $urandom_range(0, 7);
          in_valid = 1'b1;
          in_op    = 3'($urandom_range(0, 7));
          in_data  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h8000_0000 :
                     (sel == 2) ? 32'hFFFF_FFFF : $urandom;
          sel      = $urandom_range(0, 5);
          in_amt   = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd31 : 5'($urandom);
          in_tag   = 4'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) acc_n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LW + 3) @(posedge clk);
    @(negedge clk);
    chk("rand_accepted", acc_n, 3000);
    chk("rand_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/shift_rotate_pipe.md
Name: shift_rotate_pipe

Overview:
- Parametrised, pipelined successor to the CPU's single-function combinational rotate-left unit.
- Implements ROL, ROR, SHL, SHR and SRA on a WIDTH-bit operand using log2(WIDTH) registered barrel stages.
- Uses a valid/ready handshake with full-pipeline stall and passes a tag through with each operation.
- Sits in the ALU execute path; the datapath controller issues operations and retires them by tag.

Parameters:
- WIDTH, 32, operand width; power of two, 4 to 64.
- TAG_W, 4, width of the pass-through tag.
- LOGW, $clog2(WIDTH), derived; number of stages and the shift-amount width. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation present.
- in_ready  out  1  unit can accept an operation this cycle.
- in_op  in  3  000 ROL, 001 ROR, 010 SHL, 011 SHR, 100 SRA; 101-111 pass-through.
- in_data  in  WIDTH  operand.
- in_amt  in  LOGW  shift/rotate amount, 0..WIDTH-1.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0, out_data=0, out_tag=0. in_ready=1 immediately while reset is asserted and after it.
- Reset mid-operation: all in-flight operations are discarded silently.
- Stages: stage k (0..LOGW-1) registers data, op, residual amount, tag and valid. If amt bit k=1, stage k moves the data by 2^k; otherwise it passes the data unchanged.
- Shift/rotate rules:
  - ROL/ROR: bits wrap around.
  - SHL/SHR: zeros fill.
  - SRA: the operand MSB fills; the MSB is captured at stage 0 and carried along.
- amt=0 returns the operand unchanged for every op; amount is never decremented below zero.
- Pass-through ops return in_data unchanged.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- Latency: out_valid and the result appear after exactly LOGW rising edges, counting the accepting edge (5 for WIDTH=32).
- Stall: stall = out_valid && !out_ready. On stall, every stage holds and in_ready=0 (combinational). Otherwise all stages advance and in_ready=1.
- Throughput: one operation per cycle with out_ready held high. Bubbles advance and collapse; pipeline valid bits track occupancy.
- Simultaneous events: a retire (out_valid && out_ready) and an accept in the same cycle are both honoured.
- Output stability: out_data and out_tag stay stable while out_valid && !out_ready. The input side need not hold when in_ready=0; the source must hold its own operation.
- Empty pipeline: out_valid=0 and out_data holds its last value.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- When defined, adds output ports out_carry (1) and out_zero (1), registered alongside out_data.
- out_zero = (out_data==0).
- out_carry:
  - Last bit shifted out for SHL/SHR/SRA. For SHL by n this is in_data[WIDTH-n]; for SHR/SRA by n it is in_data[n-1].
  - ROL: result LSB. ROR: result MSB.
  - 0 when amt=0 or op is pass-through.
- Carry tracking per stage: an active stage overwrites carry with the bit it shifts out last; an inactive stage passes carry through.
- Both flags reset to 0.
- When undefined, neither port exists and no flag logic is built.

Decomposition:
- Package shift_pkg:
  - op enum: OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_SRA.
  - op width constant = 3.
  - stage-record struct: data, op, amt, tag, valid, fill bit, and optional carry.
- Sub-module shift_stage, parametrised by WIDTH and stage index K. It holds one stage's registered move-by-2^K logic and is instantiated LOGW times in a generate loop.

Test Plan:
- ROL in_data=0x80000001, amt=1 -> out_data=0x00000003, after 5 edges. With flags: carry=1, zero=0.
- ROR 0x12345678 amt=0; then SHL 0x00000001 amt=31 -> results 0x12345678, then 0x80000000.
- SRA 0x80000000 amt=31 -> 0xFFFFFFFF. SHR 0x80000000 amt=31 -> 0x00000001. With flags, SHR 0x00000001 amt=1 -> out_data=0, zero=1, carry=1.
- Backpressure: issue 8 back-to-back ops, hold out_ready=0 for 10 cycles, then release -> in_ready falls once out_valid is high. Results then drain in issue order, tags 0..7, one per cycle; none are lost or duplicated.
- Reset mid-flight: assert rst_n=0 asynchronously with 3 ops in flight -> out_valid=0 at once. After release no stale result appears; a new op returns correctly after 5 edges.
- Randomised: 10k ops against a reference model for WIDTH=8, 32 and 64, with random out_ready and op codes 101-111 included -> zero mismatches.
